pms_stage: RTL and testbench

PMS_STAGE -- requirements
Module: pms_stage

---
 rtl/pms_stage.sv | 135 +++++++++++++
 tb/tb_pms_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pms_stage.sv
// Pre-memory stage: issues up to two data-cache requests (one per instruction slot) and
// holds the instruction bundle until each memory op has been accepted by the cache.
module pms_stage #(
   parameter int ES_TO_PMS_BUS_WD = 233,
   parameter int PMS_TO_MS_BUS_WD = 227
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        ms_allowin,
   output logic                        pms_allowin,
   input  logic                        es_to_pms_valid,
   input  logic [ES_TO_PMS_BUS_WD-1:0] es_to_pms_bus,
   output logic                        pms_to_ms_valid,
   output logic [PMS_TO_MS_BUS_WD-1:0] pms_to_ms_bus,
   output logic                        data_cache_req_01,
   output logic                        data_cache_wr_01,
   output logic [1:0]                  data_cache_size_01,
   output logic [31:0]                 data_cache_addr_01,
   output logic [3:0]                  data_cache_wstrb_01,
   output logic [31:0]                 data_cache_wdata_01,
   input  logic                        data_cache_addr_ok_01,
   output logic                        data_cache_req_02,
   output logic                        data_cache_wr_02,
   output logic [1:0]                  data_cache_size_02,
   output logic [31:0]                 data_cache_addr_02,
   output logic [3:0]                  data_cache_wstrb_02,
   output logic [31:0]                 data_cache_wdata_02,
   input  logic                        data_cache_addr_ok_02
);

   localparam int IW = 116;

   logic                        pms_valid_q, pms_valid_d;
   logic [ES_TO_PMS_BUS_WD-1:0] bus_q, bus_d;
   logic [1:0]                  sent_q, sent_d;
   logic [1:0]                  memop, req, done, addr_ok, we;
   logic [1:0][1:0]             size;
   logic [1:0][31:0]            addr, wdata;
   logic [1:0][3:0]             wstrb;
   logic                        pms_ready_go, load;

   assign addr_ok = {data_cache_addr_ok_02, data_cache_addr_ok_01};

   for (genvar g = 0; g < 2; g++) begin : g_ch
      logic [4:0]  st;
      logic [31:0] rt, alu;
      logic [1:0]  off;
      logic        byte_op, half_op, unaligned;
      logic [3:0]  strb;
      logic [31:0] wd;

      assign st        = bus_q[g*IW+108 -: 5];
      assign rt        = bus_q[g*IW+95 -: 32];
      assign alu       = bus_q[g*IW+63 -: 32];
      assign off       = alu[1:0];
      assign we[g]     = bus_q[g*IW+102];
      assign byte_op   = bus_q[g*IW+115] | bus_q[g*IW+114] | st[4];
      assign half_op   = bus_q[g*IW+113] | bus_q[g*IW+112] | st[3];
      assign unaligned = bus_q[g*IW+110] | bus_q[g*IW+109] | st[1] | st[0];

      // Slot 2 only exists when its valid bit is set.
      assign memop[g] = (bus_q[g*IW+103] | we[g]) & ((g == 0) ? 1'b1 : bus_q[2*IW]);
      assign req[g]   = pms_valid_q & memop[g] & ~sent_q[g];
      assign done[g]  = ~memop[g] | sent_q[g] | addr_ok[g];
      assign sent_d[g] = load ? 1'b0 : ((req[g] & addr_ok[g]) ? 1'b1 : sent_q[g]);

      assign size[g] = byte_op ? 2'd0 : (half_op ? 2'd1 : 2'd2);
      assign addr[g] = unaligned ? {alu[31:2], 2'b00} : alu;

      always_comb begin
         strb = 4'b0000;
         wd   = rt;
         if (st[4]) begin
            strb = 4'b0001 << off;
            wd   = {4{rt[7:0]}};
         end else if (st[3]) begin
            strb = off[1] ? 4'b1100 : 4'b0011;
            wd   = {2{rt[15:0]}};
         end else if (st[2]) begin
            strb = 4'b1111;
         end else if (st[1]) begin
            strb = 4'b1111 >> (2'd3 - off);
            wd   = rt >> {2'd3 - off, 3'b000};
         end else if (st[0]) begin
            strb = 4'b1111 << off;
            wd   = rt << {off, 3'b000};
         end
      end

      assign wstrb[g] = we[g] ? strb : 4'b0000;
      assign wdata[g] = wd;
   end

   assign pms_ready_go    = &done;
   assign pms_allowin     = ~pms_valid_q | (pms_ready_go & ms_allowin);
   assign pms_to_ms_valid = pms_valid_q & pms_ready_go;
   assign load            = es_to_pms_valid & pms_allowin;

   always_comb begin
      pms_valid_d = pms_valid_q;
      if (pms_allowin) pms_valid_d = es_to_pms_valid;
      bus_d = load ? es_to_pms_bus : bus_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pms_valid_q <= 1'b0;
         sent_q      <= 2'b00;
      end else begin
         pms_valid_q <= pms_valid_d;
         sent_q      <= sent_d;
      end
   end

   // Payload needs no reset: it is only observed while pms_valid_q is set.
   always_ff @(posedge clk) bus_q <= bus_d;

   assign pms_to_ms_bus = {bus_q[2*IW],
                           bus_q[IW+115 -: 7], bus_q[IW+33 -: 2], bus_q[IW+103:IW],
                           bus_q[115 -: 7],    bus_q[33 -: 2],    bus_q[103:0]};

   assign data_cache_req_01   = req[0];
   assign data_cache_wr_01    = we[0];
   assign data_cache_size_01  = size[0];
   assign data_cache_addr_01  = addr[0];
   assign data_cache_wstrb_01 = wstrb[0];
   assign data_cache_wdata_01 = wdata[0];
   assign data_cache_req_02   = req[1];
   assign data_cache_wr_02    = we[1];
   assign data_cache_size_02  = size[1];
   assign data_cache_addr_02  = addr[1];
   assign data_cache_wstrb_02 = wstrb[1];
   assign data_cache_wdata_02 = wdata[1];

endmodule

// File: tb/tb_pms_stage.sv
// Directed checks of the pre-memory stage: handshakes, store alignment and bus re-pack.
module tb_pms_stage;

   localparam logic [6:0] LD_LW = 7'b0000100;
   localparam logic [6:0] LD_LH = 7'b0010000;
   localparam logic [4:0] ST_SB = 5'b10000;
   localparam logic [4:0] ST_SWL = 5'b00010;
   localparam logic [4:0] ST_SWR = 5'b00001;

   logic         clk = 1'b0;
   logic         reset, ms_allowin, pms_allowin, es_to_pms_valid, pms_to_ms_valid;
   logic [232:0] es_to_pms_bus;
   logic [226:0] pms_to_ms_bus;
   logic         req_01, wr_01, ok_01, req_02, wr_02, ok_02;
   logic [1:0]   size_01, size_02;
   logic [31:0]  addr_01, wdata_01, addr_02, wdata_02;
   logic [3:0]   wstrb_01, wstrb_02;

   int vectors = 0;
   int miscompares = 0;
   int hs1, hs2;

   always #5 clk = ~clk;

   pms_stage dut (
      .clk(clk), .reset(reset), .ms_allowin(ms_allowin), .pms_allowin(pms_allowin),
      .es_to_pms_valid(es_to_pms_valid), .es_to_pms_bus(es_to_pms_bus),
      .pms_to_ms_valid(pms_to_ms_valid), .pms_to_ms_bus(pms_to_ms_bus),
      .data_cache_req_01(req_01), .data_cache_wr_01(wr_01), .data_cache_size_01(size_01),
      .data_cache_addr_01(addr_01), .data_cache_wstrb_01(wstrb_01),
      .data_cache_wdata_01(wdata_01), .data_cache_addr_ok_01(ok_01),
      .data_cache_req_02(req_02), .data_cache_wr_02(wr_02), .data_cache_size_02(size_02),
      .data_cache_addr_02(addr_02), .data_cache_wstrb_02(wstrb_02),
      .data_cache_wdata_02(wdata_02), .data_cache_addr_ok_02(ok_02)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [115:0] mk(input logic [6:0] lt, input logic [4:0] st,
                                       input logic rfm, input logic mwe, input logic grwe,
                                       input logic [4:0] dest, input logic [31:0] rt,
                                       input logic [31:0] alu, input logic [31:0] pc);
      return {lt, st, rfm, mwe, grwe, dest, rt, alu, pc};
   endfunction

   function automatic logic [112:0] mko(input logic [6:0] lt, input logic [1:0] off,
                                        input logic rfm, input logic mwe, input logic grwe,
                                        input logic [4:0] dest, input logic [31:0] rt,
                                        input logic [31:0] alu, input logic [31:0] pc);
      return {lt, off, rfm, mwe, grwe, dest, rt, alu, pc};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   initial begin
      reset = 1'b1; ms_allowin = 1'b1; es_to_pms_valid = 1'b0; es_to_pms_bus = '0;
      ok_01 = 1'b0; ok_02 = 1'b0;
      tick(); tick(); settle();
      check("rst_to_ms_valid", pms_to_ms_valid, 0);
      check("rst_allowin", pms_allowin, 1);
      check("rst_req_01", req_01, 0);
      check("rst_req_02", req_02, 0);
      reset = 1'b0;

      // lw accepted on its first cycle
      es_to_pms_valid = 1'b1;
      es_to_pms_bus = {1'b0, 116'b0, mk(LD_LW, 5'b0, 1, 0, 1, 5'd3, 32'h0, 32'h1000, 32'hbfc0_0000)};
      tick();
      es_to_pms_valid = 1'b0; ok_01 = 1'b1; settle();
      check("lw_req", req_01, 1);
      check("lw_wr", wr_01, 0);
      check("lw_size", size_01, 2);
      check("lw_addr", addr_01, 32'h1000);
      check("lw_wstrb", wstrb_01, 0);
      check("lw_to_ms_valid", pms_to_ms_valid, 1);
      check("lw_allowin", pms_allowin, 1);
      check("lw_out_bus", pms_to_ms_bus[112:0],
            mko(LD_LW, 2'b00, 1, 0, 1, 5'd3, 32'h0, 32'h1000, 32'hbfc0_0000));
      tick();
      ok_01 = 1'b0; settle();
      check("lw_no_rereq", req_01, 0);
      check("lw_drained", pms_to_ms_valid, 0);

      // sb with acceptance delayed three cycles
      es_to_pms_valid = 1'b1;
      es_to_pms_bus = {1'b0, 116'b0, mk(7'b0, ST_SB, 0, 1, 0, 5'd0, 32'h0000_00AB, 32'h2003, 32'h44)};
      tick();
      es_to_pms_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         check("sb_req_held", req_01, 1);
         check("sb_addr", addr_01, 32'h2003);
         check("sb_wstrb", wstrb_01, 4'b1000);
         check("sb_wdata", wdata_01, 32'hABAB_ABAB);
         check("sb_size", size_01, 0);
         check("sb_allowin_low", pms_allowin, 0);
         tick();
      end
      ok_01 = 1'b1; settle();
      check("sb_req_accept", req_01, 1);
      check("sb_wr", wr_01, 1);
      check("sb_allowin", pms_allowin, 1);
      check("sb_to_ms_valid", pms_to_ms_valid, 1);
      check("sb_out_bus", pms_to_ms_bus[112:0],
            mko(7'b0, 2'b11, 0, 1, 0, 5'd0, 32'h0000_00AB, 32'h2003, 32'h44));
      tick();
      ok_01 = 1'b0; settle();
      check("sb_no_rereq", req_01, 0);

      // swr in slot 1, swl in slot 2
      es_to_pms_valid = 1'b1;
      es_to_pms_bus = {1'b1, mk(7'b0, ST_SWL, 0, 1, 0, 5'd0, 32'h1122_3344, 32'h4002, 32'h54),
                             mk(7'b0, ST_SWR, 0, 1, 0, 5'd0, 32'h1122_3344, 32'h3001, 32'h50)};
      tick();
      es_to_pms_valid = 1'b0; settle();
      check("swr_req", req_01, 1);
      check("swl_req", req_02, 1);
      check("swr_addr", addr_01, 32'h3000);
      check("swr_wstrb", wstrb_01, 4'b1110);
      check("swr_wdata", wdata_01, 32'h2233_4400);
      check("swl_addr", addr_02, 32'h4000);
      check("swl_wstrb", wstrb_02, 4'b0111);
      check("swl_wdata", wdata_02, 32'h0011_2233);
      check("swl_size", size_02, 2);
      ok_01 = 1'b1; ok_02 = 1'b1; settle();
      check("sw_pair_to_ms_valid", pms_to_ms_valid, 1);
      tick();
      ok_01 = 1'b0; ok_02 = 1'b0;

      // dual loads, staggered acceptance, downstream stalled until cycle 5
      ms_allowin = 1'b0; es_to_pms_valid = 1'b1;
      es_to_pms_bus = {1'b1, mk(LD_LH, 5'b0, 1, 0, 1, 5'd4, 32'h0, 32'h202, 32'h64),
                             mk(LD_LW, 5'b0, 1, 0, 1, 5'd5, 32'h0, 32'h100, 32'h60)};
      tick();
      es_to_pms_valid = 1'b0; hs1 = 0; hs2 = 0;
      for (int c = 0; c < 6; c++) begin
         ok_01 = (c == 0); ok_02 = (c == 2); ms_allowin = (c == 5);
         settle();
         hs1 += int'(req_01 & ok_01);
         hs2 += int'(req_02 & ok_02);
         check("dl_to_ms_valid", pms_to_ms_valid, c >= 2);
         check("dl_allowin", pms_allowin, c == 5);
         if (c == 0) begin
            check("dl_size_02", size_02, 1);
            check("dl_addr_02", addr_02, 32'h202);
         end
         if (c == 1) begin
            check("dl_req_01_after_ok", req_01, 0);
            check("dl_req_02_pending", req_02, 1);
         end
         if (c == 5)
            check("dl_out_bus_inst2", pms_to_ms_bus[226:113],
                  {1'b1, mko(LD_LH, 2'b10, 1, 0, 1, 5'd4, 32'h0, 32'h202, 32'h64)});
         tick();
      end
      ok_01 = 1'b0; ok_02 = 1'b0; ms_allowin = 1'b1; settle();
      check("dl_handshakes_01", hs1, 1);
      check("dl_handshakes_02", hs2, 1);
      check("dl_drained", pms_to_ms_valid, 0);

      // ALU-only back to back; slot 2 carries a store but is not valid
      es_to_pms_valid = 1'b1;
      es_to_pms_bus = {1'b0, mk(7'b0, 5'b00100, 0, 1, 0, 5'd0, 32'h0, 32'h5000, 32'h40),
                             mk(7'b0, 5'b0, 0, 0, 1, 5'd7, 32'h0, 32'h1234, 32'h10)};
      tick();
      es_to_pms_bus = {1'b0, 116'b0, mk(7'b0, 5'b0, 0, 0, 1, 5'd8, 32'h0, 32'h5678, 32'h14)};
      settle();
      check("alu_a_req_01", req_01, 0);
      check("alu_a_req_02_invalid_slot", req_02, 0);
      check("alu_a_to_ms_valid", pms_to_ms_valid, 1);
      check("alu_a_allowin", pms_allowin, 1);
      check("alu_a_pc", pms_to_ms_bus[31:0], 32'h10);
      tick();
      es_to_pms_valid = 1'b0; settle();
      check("alu_b_to_ms_valid", pms_to_ms_valid, 1);
      check("alu_b_pc", pms_to_ms_bus[31:0], 32'h14);
      check("alu_b_req_01", req_01, 0);
      tick(); settle();
      check("alu_drained", pms_to_ms_valid, 0);

      // reset while slot 2 request is outstanding
      es_to_pms_valid = 1'b1;
      es_to_pms_bus = {1'b1, mk(LD_LW, 5'b0, 1, 0, 1, 5'd9, 32'h0, 32'h300, 32'h74),
                             mk(7'b0, 5'b0, 0, 0, 1, 5'd1, 32'h0, 32'h1, 32'h70)};
      tick();
      es_to_pms_valid = 1'b0; settle();
      check("rr_req_02_pending", req_02, 1);
      check("rr_req_01_idle", req_01, 0);
      check("rr_allowin_low", pms_allowin, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0; settle();
      check("rr_req_02_dropped", req_02, 0);
      check("rr_to_ms_valid", pms_to_ms_valid, 0);
      check("rr_allowin", pms_allowin, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
